mem_arb: RTL

- Two-requester arbiter for the single data port of the 16KB `ram` block (`d_addr`/`d_in`/`d_size`/`w_en`/`u_en`/`d_out`).
- Requester 0 is the core load/store unit. Requester 1 is the debug/program loader.
- Round-robin arbitration; rejects misaligned or illegal-size accesses without touching RAM.
- Tracks the RAM's one-cycle registered read latency and returns read data to the requester that issued the read.

---
 rtl/mem_arb.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing the RAM data port between the load/store unit (m0)
// and the debug loader (m1); rejects misaligned/illegal accesses and routes read data back.
module mem_arb #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_uns,
    input  logic [1:0]    m0_size,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_uns,
    input  logic [1:0]    m1_size,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,

    output logic          ram_w_en,
    output logic          ram_u_en,
    output logic [AW-1:0] ram_d_addr,
    output logic [DW-1:0] ram_d_in,
    output logic [1:0]    ram_d_size,
    input  logic [DW-1:0] ram_d_out
);

    logic last_q,     last_d;
    logic pend_v_q,   pend_v_d;
    logic pend_id_q,  pend_id_d;
    logic pend_err_q, pend_err_d;

    logic bad0, bad1;
    logic gnt0, gnt1, any_gnt;
    logic sel_bad, sel_we;

    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] a_lo);
        return (size == 2'b11) |
               ((size == 2'b01) & a_lo[0]) |
               ((size == 2'b10) & (a_lo != 2'b00));
    endfunction

    always_comb begin
        bad0 = is_bad(m0_size, m0_addr[1:0]);
        bad1 = is_bad(m1_size, m1_addr[1:0]);

        // The requester that did not win last time gets priority under contention.
        gnt0 = rst_n & m0_req & (~m1_req | last_q);
        gnt1 = rst_n & m1_req & (~m0_req | ~last_q);
        any_gnt = gnt0 | gnt1;

        sel_bad = gnt1 ? bad1  : bad0;
        sel_we  = gnt1 ? m1_we : m0_we;

        // With no grant the bus idles on m0's inputs; the resulting read is never returned.
        ram_d_addr = gnt1 ? m1_addr  : m0_addr;
        ram_d_size = gnt1 ? m1_size  : m0_size;
        ram_d_in   = gnt1 ? m1_wdata : m0_wdata;
        ram_u_en   = gnt1 ? m1_uns   : m0_uns;
        ram_w_en   = any_gnt & sel_we & ~sel_bad;

        m0_gnt = gnt0;
        m1_gnt = gnt1;
    end

    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end

        // Loads and rejected accesses owe a response next cycle; good stores do not.
        pend_v_d   = any_gnt & (sel_bad | ~sel_we);
        pend_id_d  = gnt1;
        pend_err_d = sel_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            pend_v_q   <= 1'b0;
            pend_id_q  <= 1'b0;
            pend_err_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            pend_v_q   <= pend_v_d;
            pend_id_q  <= pend_id_d;
            pend_err_q <= pend_err_d;
        end
    end

    always_comb begin
        m0_rvalid = pend_v_q & ~pend_err_q & ~pend_id_q;
        m1_rvalid = pend_v_q & ~pend_err_q &  pend_id_q;
        m0_err    = pend_v_q &  pend_err_q & ~pend_id_q;
        m1_err    = pend_v_q &  pend_err_q &  pend_id_q;
        m0_rdata  = ram_d_out;
        m1_rdata  = ram_d_out;
    end

endmodule
